// File: rtl/ram_port_arbiter.sv
// Two-master round-robin arbiter in front of a single-port RAM slave.
// Routes fixed-latency read data back to whichever master issued the read.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned BE_W       = 4,
  parameter int unsigned RD_LATENCY = 1    // 1: unregistered RAM q, 2: registered q
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);

  logic req0, req1;
  logic grant0, grant1;
  logic rr_ptr_q, rr_ptr_d;
  logic rd_accept;

  logic [RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [RD_LATENCY-1:0] pipe_own_q, pipe_own_d;
  logic                  tail_vld, tail_own;

  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // rr_ptr_q names the master that wins when both request.
  always_comb begin
    grant0 = req0 & (~req1 | ~rr_ptr_q);
    grant1 = req1 & (~req0 |  rr_ptr_q);
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant0) begin
      rr_ptr_d = 1'b1;
    end else if (grant1) begin
      rr_ptr_d = 1'b0;
    end
  end

  assign m0_waitrequest = req0 & ~grant0;
  assign m1_waitrequest = req1 & ~grant1;

  // A simultaneous read+write is treated as a write only.
  assign rd_accept = (grant0 & m0_read & ~m0_write) | (grant1 & m1_read & ~m1_write);

  always_comb begin
    ram_chipselect = grant0 | grant1;
    ram_write      = 1'b0;
    ram_address    = m0_address;
    ram_byteenable = m0_byteenable;
    ram_writedata  = m0_writedata;
    if (grant1) begin
      ram_write      = m1_write;
      ram_address    = m1_address;
      ram_byteenable = m1_byteenable;
      ram_writedata  = m1_writedata;
    end else if (grant0) begin
      ram_write      = m0_write;
    end
  end

  assign ram_clken = reset_n;

  always_comb begin
    pipe_vld_d    = pipe_vld_q;
    pipe_own_d    = pipe_own_q;
    for (int i = RD_LATENCY - 1; i > 0; i--) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_own_d[i] = pipe_own_q[i-1];
    end
    pipe_vld_d[0] = rd_accept;
    pipe_own_d[0] = rd_accept & grant1;
  end

  assign tail_vld = pipe_vld_q[RD_LATENCY-1];
  assign tail_own = pipe_own_q[RD_LATENCY-1];

  assign m0_readdatavalid = tail_vld & ~tail_own;
  assign m1_readdatavalid = tail_vld &  tail_own;

  // Pass RAM data straight through on the valid cycle, otherwise hold the last word.
  assign m0_readdata = m0_readdatavalid ? ram_readdata : rdata0_q;
  assign m1_readdata = m1_readdatavalid ? ram_readdata : rdata1_q;
  assign rdata0_d    = m0_readdata;
  assign rdata1_d    = m1_readdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q   <= 1'b0;
      pipe_vld_q <= '0;
      pipe_own_q <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_own_q <= pipe_own_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, directed stimulus, scoreboarded read responses.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [15:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_writedata, ram_readdata;

  typedef struct packed {
    logic        owner;
    logic [31:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .ADDR_W    (16),
    .DATA_W    (32),
    .BE_W      (4),
    .RD_LATENCY(1)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .m0_address      (m0_address),
    .m0_byteenable   (m0_byteenable),
    .m0_read         (m0_read),
    .m0_write        (m0_write),
    .m0_writedata    (m0_writedata),
    .m0_waitrequest  (m0_waitrequest),
    .m0_readdata     (m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address      (m1_address),
    .m1_byteenable   (m1_byteenable),
    .m1_read         (m1_read),
    .m1_write        (m1_write),
    .m1_writedata    (m1_writedata),
    .m1_waitrequest  (m1_waitrequest),
    .m1_readdata     (m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .ram_address     (ram_address),
    .ram_byteenable  (ram_byteenable),
    .ram_chipselect  (ram_chipselect),
    .ram_write       (ram_write),
    .ram_writedata   (ram_writedata),
    .ram_clken       (ram_clken),
    .ram_readdata    (ram_readdata)
  );

  // Single-port RAM with registered address and unregistered q (read latency 1).
  logic [31:0] mem [0:255];
  logic [15:0] ram_addr_q;
  assign ram_readdata = mem[ram_addr_q[7:0]];

  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_byteenable[b]) mem[ram_address[7:0]][8*b +: 8] <= ram_writedata[8*b +: 8];
        end
      end
      ram_addr_q <= ram_address;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    rsp_t r;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (m0_readdatavalid) begin
          if (exp_q.size() == 0) begin
            check("m0_rdv_unexpected", 32'(m0_readdatavalid), 32'd0);
          end else begin
            r = exp_q.pop_front();
            check("m0_rsp_owner", 32'(r.owner), 32'd0);
            check("m0_rsp_data", m0_readdata, r.data);
          end
        end
        if (m1_readdatavalid) begin
          if (exp_q.size() == 0) begin
            check("m1_rdv_unexpected", 32'(m1_readdatavalid), 32'd0);
          end else begin
            r = exp_q.pop_front();
            check("m1_rsp_owner", 32'(r.owner), 32'd1);
            check("m1_rsp_data", m1_readdata, r.data);
          end
        end
      end
    end
  endtask

  task automatic idle();
    m0_read  = 1'b0;
    m0_write = 1'b0;
    m1_read  = 1'b0;
    m1_write = 1'b0;
  endtask

  task automatic set_m(input int m, input logic rd, input logic wr, input logic [15:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
    end
  endtask

  // One uncontended transfer; reads register their expected response first.
  task automatic xfer(input int m, input logic wr, input logic [15:0] a, input logic [3:0] be,
                      input logic [31:0] d, input logic [31:0] exp_rd);
    set_m(m, ~wr, wr, a, be, d);
    if (!wr) exp_q.push_back('{owner: m[0], data: exp_rd});
    @(negedge clk);
    check("xfer_wait", 32'((m == 0) ? m0_waitrequest : m1_waitrequest), 32'd0);
    @(posedge clk); #1;
    idle();
  endtask

  task automatic apply_reset();
    idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic contend(input logic [15:0] a0, input logic [15:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
    set_m(0, 1'b1, 1'b0, a0, 4'hF, 32'd0);
    set_m(1, 1'b1, 1'b0, a1, 4'hF, 32'd0);
    exp_q.push_back('{owner: 1'b0, data: d0});
    exp_q.push_back('{owner: 1'b1, data: d1});
    @(negedge clk);
    check("cont_m0_wait", 32'(m0_waitrequest), 32'd0);
    check("cont_m1_wait", 32'(m1_waitrequest), 32'd1);
    @(posedge clk); #1;
    m0_read = 1'b0;
    @(negedge clk);
    check("cont_m1_wait2", 32'(m1_waitrequest), 32'd0);
    check("cont_m0_rdv", 32'(m0_readdatavalid), 32'd1);
    @(posedge clk); #1;
    m1_read = 1'b0;
    @(negedge clk);
    check("cont_m1_rdv", 32'(m1_readdatavalid), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int c0, c1, guard;
    m0_address = '0; m1_address = '0; m0_byteenable = '0; m1_byteenable = '0;
    m0_writedata = '0; m1_writedata = '0;
    idle();
    reset_n = 1'b0;
    m0_read = 1'b1;
    m1_read = 1'b1;
    fork
      monitor();
    join_none

    // Reset behaviour
    @(negedge clk);
    check("rst_clken", 32'(ram_clken), 32'd0);
    check("rst_m0_rdv", 32'(m0_readdatavalid), 32'd0);
    check("rst_m1_rdv", 32'(m1_readdatavalid), 32'd0);
    check("rst_m0_rdata", m0_readdata, 32'd0);
    @(negedge clk);
    idle();
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_m0_wait", 32'(m0_waitrequest), 32'd0);
    check("post_rst_m1_wait", 32'(m1_waitrequest), 32'd0);
    check("post_rst_clken", 32'(ram_clken), 32'd1);
    check("post_rst_cs", 32'(ram_chipselect), 32'd0);
    @(posedge clk); #1;

    // Preload words used later
    xfer(0, 1'b1, 16'h0000, 4'hF, 32'hA0A0_0000, 32'd0);
    xfer(0, 1'b1, 16'h0001, 4'hF, 32'hB1B1_0001, 32'd0);
    xfer(1, 1'b1, 16'h0020, 4'hF, 32'hFFFF_FFFF, 32'd0);

    // Single master write then read
    xfer(0, 1'b1, 16'h0010, 4'hF, 32'hDEAD_BEEF, 32'd0);
    set_m(0, 1'b1, 1'b0, 16'h0010, 4'hF, 32'd0);
    exp_q.push_back('{owner: 1'b0, data: 32'hDEAD_BEEF});
    @(negedge clk);
    check("single_rd_wait", 32'(m0_waitrequest), 32'd0);
    check("single_rd_cs", 32'(ram_chipselect), 32'd1);
    check("single_rd_we", 32'(ram_write), 32'd0);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check("single_m0_rdv", 32'(m0_readdatavalid), 32'd1);
    check("single_m0_rdata", m0_readdata, 32'hDEAD_BEEF);
    check("single_m1_rdv", 32'(m1_readdatavalid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("single_m0_rdv_once", 32'(m0_readdatavalid), 32'd0);
    check("single_m0_hold", m0_readdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;

    // Contention from reset: m0 first, then m1
    apply_reset();
    contend(16'h0000, 16'h0001, 32'hA0A0_0000, 32'hB1B1_0001);

    // Fairness: 8 writes each, alternating grants
    c0 = 0;
    c1 = 0;
    for (int c = 0; c < 16; c++) begin
      if (c0 < 8) set_m(0, 1'b0, 1'b1, 16'(32'h40 + c0), 4'hF, 32'h4000_0000 + c0);
      else m0_write = 1'b0;
      if (c1 < 8) set_m(1, 1'b0, 1'b1, 16'(32'h50 + c1), 4'hF, 32'h5000_0000 + c1);
      else m1_write = 1'b0;
      @(negedge clk);
      check($sformatf("fair_addr%0d", c), 32'(ram_address),
            (c % 2 == 0) ? 32'h40 + c / 2 : 32'h50 + c / 2);
      if (m0_write && !m0_waitrequest) c0++;
      if (m1_write && !m1_waitrequest) c1++;
      @(posedge clk); #1;
    end
    idle();
    check("fair_m0_grants", 32'(c0), 32'd8);
    check("fair_m1_grants", 32'(c1), 32'd8);

    // Byte enables, write then read on consecutive accepts
    xfer(1, 1'b1, 16'h0020, 4'h5, 32'h1122_3344, 32'd0);
    xfer(0, 1'b0, 16'h0020, 4'hF, 32'd0, 32'hFF22_FF44);
    @(posedge clk); #1;

    // Reset on the cycle after a read accept discards it
    set_m(0, 1'b1, 1'b0, 16'h0010, 4'hF, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    idle();
    @(negedge clk);
    check("rst_mid_m0_rdv", 32'(m0_readdatavalid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_mid_after_rdv", 32'(m0_readdatavalid), 32'd0);
    end
    @(posedge clk); #1;
    contend(16'h0010, 16'h0020, 32'hDEAD_BEEF, 32'hFF22_FF44);

    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    check("drain_queue", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
